// File: rtl/dht11_poll_scheduler_if.sv
// Reader handshake: one-cycle start request out, frame strobe and 40-bit frame back.
interface dht11_poll_scheduler_if;
  logic        rd_start;
  logic        rd_valid;
  logic [39:0] rd_data;

  // Scheduler side
  modport master (output rd_start, input rd_valid, input rd_data);
  // Reader side
  modport slave  (input rd_start, output rd_valid, output rd_data);
endinterface

// File: rtl/dht11_poll_scheduler.sv
// DHT11 poll scheduler: periodic start requests, frame timeout, checksum
// validation, bounded retries and last-good-value holding with fault flag.
module dht11_poll_scheduler #(
  parameter int unsigned POLL_CYCLES      = 20000000,
  parameter int unsigned TIMEOUT_CYCLES   = 100000,
  parameter int unsigned RETRY_GAP_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          force_poll,
  dht11_poll_scheduler_if.master        rd_bus,
  output logic [7:0]                    humidity,
  output logic [7:0]                    temperature,
  output logic                          sample_valid,
  output logic                          sensor_fault,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  localparam int unsigned CNT_MAX = (POLL_CYCLES > RETRY_GAP_CYCLES) ? POLL_CYCLES : RETRY_GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TCNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TCNT_W-1:0]  tcnt, tcnt_d;
  logic [RTY_W-1:0]   retry, retry_d;
  logic [39:0]        frame, frame_d;
  logic [7:0]         hum_d, temp_d, err_d;
  logic               sv_d, fault_d, start_d, busy_d;
  logic               fail;
  logic [7:0]         sum;

  // Checksum over the four data bytes, wrapping at 8 bits
  assign sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

  // Next-state and next-output logic; failure handling is shared by WAIT and CHECK
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    tcnt_d  = tcnt;
    retry_d = retry;
    frame_d = frame;
    hum_d   = humidity;
    temp_d  = temperature;
    err_d   = err_count;
    fault_d = sensor_fault;
    sv_d    = 1'b0;
    fail    = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          if (cnt == '0 || force_poll) state_d = S_START;
          else                         cnt_d   = cnt - CNT_W'(1);
        end
      end
      S_START: begin
        tcnt_d  = TCNT_W'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_bus.rd_valid) begin
          frame_d = rd_bus.rd_data;
          state_d = S_CHECK;
        end else if (tcnt == '0) begin
          fail = 1'b1;
        end else begin
          tcnt_d = tcnt - TCNT_W'(1);
        end
      end
      S_CHECK: begin
        if (sum == frame[7:0]) begin
          hum_d   = frame[39:32];
          temp_d  = frame[23:16];
          sv_d    = 1'b1;
          fault_d = 1'b0;
          retry_d = '0;
          cnt_d   = CNT_W'(POLL_CYCLES - 1);
          state_d = S_IDLE;
        end else begin
          fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      if (err_count != 8'hFF) err_d = err_count + 8'd1;
      if (retry < RTY_W'(MAX_RETRY)) begin
        retry_d = retry + RTY_W'(1);
        cnt_d   = CNT_W'(RETRY_GAP_CYCLES - 1);
      end else begin
        fault_d = 1'b1;
        retry_d = '0;
        cnt_d   = CNT_W'(POLL_CYCLES - 1);
      end
      state_d = S_IDLE;
    end

    // rd_start and busy are registered from the next state so they line up with it
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      tcnt            <= '0;
      retry           <= '0;
      frame           <= '0;
      humidity        <= '0;
      temperature     <= '0;
      sample_valid    <= 1'b0;
      sensor_fault    <= 1'b0;
      err_count       <= '0;
      busy            <= 1'b0;
      rd_bus.rd_start <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      tcnt            <= tcnt_d;
      retry           <= retry_d;
      frame           <= frame_d;
      humidity        <= hum_d;
      temperature     <= temp_d;
      sample_valid    <= sv_d;
      sensor_fault    <= fault_d;
      err_count       <= err_d;
      busy            <= busy_d;
      rd_bus.rd_start <= start_d;
    end
  end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Directed bench for dht11_poll_scheduler with short timing parameters.
module tb_dht11_poll_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       force_poll;
  logic [7:0] humidity, temperature, err_count;
  logic       sample_valid, sensor_fault, busy;

  int errors = 0;
  int checks = 0;
  int n;

  dht11_poll_scheduler_if bus ();

  dht11_poll_scheduler #(
    .POLL_CYCLES      (100),
    .TIMEOUT_CYCLES   (20),
    .RETRY_GAP_CYCLES (10),
    .MAX_RETRY        (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .force_poll   (force_poll),
    .rd_bus       (bus.master),
    .humidity     (humidity),
    .temperature  (temperature),
    .sample_valid (sample_valid),
    .sensor_fault (sensor_fault),
    .err_count    (err_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance k rising edges; land 1 time unit after the last one
  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Steps until rd_start is seen high, bounded by budget
  task automatic wait_start(input int budget, output int cnt);
    cnt = 0;
    while (bus.rd_start !== 1'b1 && cnt < budget) begin
      step(1);
      cnt++;
    end
  endtask

  // Steps until busy drops, bounded by budget
  task automatic wait_idle(input int budget, output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < budget) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic send_frame(input logic [39:0] d);
    bus.rd_valid = 1'b1;
    bus.rd_data  = d;
    step(1);
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    force_poll   = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    step(2);

    // Reset state
    chk("rst_hum", humidity, 0);
    chk("rst_temp", temperature, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_fault", sensor_fault, 0);
    chk("rst_err", err_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.rd_start, 0);

    // 1: first poll on first enabled cycle, good frame 5 cycles after rd_start
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);
    chk("t1_start", bus.rd_start, 1);
    chk("t1_busy", busy, 1);
    step(1);
    chk("t1_start_1cyc", bus.rd_start, 0);
    step(4);
    send_frame(40'h32_00_19_00_4B);
    chk("t1_sv_early", sample_valid, 0);
    chk("t1_hum_early", humidity, 0);
    step(1);
    chk("t1_hum", humidity, 8'd50);
    chk("t1_temp", temperature, 8'd25);
    chk("t1_sv", sample_valid, 1);
    chk("t1_err", err_count, 0);
    chk("t1_busy_idle", busy, 0);
    step(1);
    chk("t1_sv_pulse", sample_valid, 0);
    wait_start(300, n);
    chk("t1_poll_gap", n, 99);

    // 2: wrapping checksum accepted, bad checksum rejected and retried
    step(1);
    send_frame(40'hFF_01_00_00_00);
    step(1);
    chk("t2_sv", sample_valid, 1);
    chk("t2_hum_ff", humidity, 8'hFF);
    chk("t2_temp", temperature, 8'h00);
    wait_start(300, n);
    chk("t2_poll_gap", n, 100);
    step(1);
    send_frame(40'h32_00_19_00_4C);
    step(1);
    chk("t2_err", err_count, 1);
    chk("t2_hum_kept", humidity, 8'hFF);
    chk("t2_sv_none", sample_valid, 0);
    chk("t2_fault", sensor_fault, 0);
    wait_start(100, n);
    chk("t2_retry_gap", n, 10);
    // retry succeeds, clearing the retry count
    step(1);
    send_frame(40'h32_00_19_00_4B);
    step(1);
    chk("t2_retry_sv", sample_valid, 1);
    chk("t2_retry_hum", humidity, 8'h32);
    chk("t2_retry_err", err_count, 1);
    wait_start(300, n);
    chk("t2_retry_poll_gap", n, 100);

    // 3: three timeouts; START edge plus 20 WAIT cycles each
    wait_idle(100, n);
    chk("t3_wait1", n, 21);
    chk("t3_err1", err_count, 2);
    chk("t3_fault1", sensor_fault, 0);
    wait_start(100, n);
    chk("t3_gap1", n, 10);
    wait_idle(100, n);
    chk("t3_wait2", n, 21);
    chk("t3_err2", err_count, 3);
    chk("t3_fault2", sensor_fault, 0);
    wait_start(100, n);
    chk("t3_gap2", n, 10);
    wait_idle(100, n);
    chk("t3_wait3", n, 21);
    chk("t3_err3", err_count, 4);
    chk("t3_fault3", sensor_fault, 1);
    chk("t3_hum", humidity, 8'h32);
    chk("t3_temp", temperature, 8'h19);
    wait_start(300, n);
    chk("t3_fault_gap", n, 100);

    // 4: good frame clears the fault
    step(1);
    send_frame(40'h32_00_19_00_4B);
    step(1);
    chk("t4_fault_clr", sensor_fault, 0);
    chk("t4_sv", sample_valid, 1);
    chk("t4_err", err_count, 4);

    // 5: force_poll at cnt=60, ignored force_poll/rd_valid, enable freeze
    step(39);
    chk("t5_pre_force", bus.rd_start, 0);
    force_poll = 1'b1;
    step(1);
    force_poll = 1'b0;
    chk("t5_force_start", bus.rd_start, 1);
    step(1);
    force_poll = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t5_wait_no_start", bus.rd_start, 0);
    end
    send_frame(40'h28_00_14_00_3C);
    step(1);
    force_poll = 1'b0;
    chk("t5_hum", humidity, 8'h28);
    chk("t5_temp", temperature, 8'h14);
    chk("t5_sv", sample_valid, 1);
    bus.rd_valid = 1'b1;
    bus.rd_data  = 40'h11_00_11_00_22;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_idle_no_start", bus.rd_start, 0);
    end
    bus.rd_valid = 1'b0;
    chk("t5_stray_hum", humidity, 8'h28);
    chk("t5_stray_busy", busy, 0);
    enable = 1'b0;
    wait_start(500, n);
    chk("t5_disabled_no_start", bus.rd_start, 0);
    enable = 1'b1;
    wait_start(300, n);
    chk("t5_frozen_cnt", n, 95);

    // 6: reset during WAIT abandons the frame
    step(3);
    chk("t6_busy_wait", busy, 1);
    rst_n = 1'b0;
    step(1);
    chk("t6_hum", humidity, 0);
    chk("t6_temp", temperature, 0);
    chk("t6_err", err_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_start", bus.rd_start, 0);
    rst_n = 1'b1;
    send_frame(40'h32_00_19_00_4B);
    chk("t6_restart", bus.rd_start, 1);
    chk("t6_sv_none", sample_valid, 0);
    step(4);
    chk("t6_hum_ignored", humidity, 0);
    chk("t6_sv_ignored", sample_valid, 0);
    chk("t6_still_wait", busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
